// File: rtl/dct_mcu_sched.sv
// dct_mcu_sched: feeds 8x8 blocks from the Y, Cb and Cr buffers into the shared
// DCT_2D engine in JPEG MCU order (Y0..Y{Y_BLOCKS-1}, Cb, Cr).
// Only one block is in flight at a time. The engine has a fixed latency, and its
// output is held as a tagged valid/ready result until the quantizer accepts it.
// Optional feature macro: DCT_SCHED_STATS_EN. When it is defined, stat_blocks and
// stat_stall are live saturating counters. When it is not defined, both ports are
// tied to zero.
module dct_mcu_sched #(
  parameter int Y_BLOCKS    = 4,   // 1, 2 or 4
  parameter int DCT_LATENCY = 24,  // >= 2
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             y_req,
  input  logic             cb_req,
  input  logic             cr_req,
  output logic             y_ack,
  output logic             cb_ack,
  output logic             cr_ack,
  output logic [1:0]       src_sel,
  output logic             dct_enable,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_comp,
  output logic [2:0]       out_idx,
  output logic             mcu_done,
  output logic [CNT_W-1:0] stat_blocks,
  output logic [CNT_W-1:0] stat_stall
);

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // The counter only has to hold DCT_LATENCY-1 down to 0.
  localparam int              LAT_W    = (DCT_LATENCY > 2) ? $clog2(DCT_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DCT_LATENCY - 1);
  localparam logic [2:0]       CB_POS   = 3'(Y_BLOCKS);
  localparam logic [2:0]       CR_POS   = 3'(Y_BLOCKS + 1);

  state_e           state_q, state_d;
  logic [2:0]       seq_pos_q, seq_pos_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             flush_pending_q, flush_pending_d;
  logic             y_ack_q, y_ack_d;
  logic             cb_ack_q, cb_ack_d;
  logic             cr_ack_q, cr_ack_d;
  comp_e            src_sel_q, src_sel_d;
  logic             dct_enable_q, dct_enable_d;
  logic             out_valid_q, out_valid_d;
  comp_e            out_comp_q, out_comp_d;
  logic [2:0]       out_idx_q, out_idx_d;
  logic             mcu_done_q, mcu_done_d;

  comp_e exp_comp;
  logic  exp_req;
  logic  start;

  // Decode which component the MCU order expects next, and select its request.
  always_comb begin
    if (seq_pos_q < CB_POS) begin
      exp_comp = COMP_Y;
      exp_req  = y_req;
    end else if (seq_pos_q == CB_POS) begin
      exp_comp = COMP_CB;
      exp_req  = cb_req;
    end else begin
      exp_comp = COMP_CR;
      exp_req  = cr_req;
    end
  end

  // A flush sampled in IDLE restarts the order and starts no block in that cycle.
  assign start = (state_q == ST_IDLE) && !flush && exp_req;

  // Next-state logic for the scheduler FSM and all of its registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without it, a
    // path that does not assign the signal would infer a latch.
    state_d         = state_q;
    seq_pos_d       = seq_pos_q;
    lat_cnt_d       = lat_cnt_q;
    flush_pending_d = flush_pending_q;
    y_ack_d         = 1'b0;
    cb_ack_d        = 1'b0;
    cr_ack_d        = 1'b0;
    dct_enable_d    = 1'b0;
    mcu_done_d      = 1'b0;
    src_sel_d       = src_sel_q;
    out_valid_d     = out_valid_q;
    out_comp_d      = out_comp_q;
    out_idx_d       = out_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          seq_pos_d       = '0;
          flush_pending_d = 1'b0;
        end else if (start) begin
          state_d      = ST_WAIT;
          lat_cnt_d    = LAT_LOAD;
          dct_enable_d = 1'b1;
          src_sel_d    = exp_comp;
          out_comp_d   = exp_comp;
          out_idx_d    = seq_pos_q;
          y_ack_d      = (exp_comp == COMP_Y);
          cb_ack_d     = (exp_comp == COMP_CB);
          cr_ack_d     = (exp_comp == COMP_CR);
        end
      end

      ST_WAIT: begin
        if (flush) flush_pending_d = 1'b1;
        // out_valid rises exactly DCT_LATENCY cycles after the dct_enable cycle.
        if (lat_cnt_q == '0) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d         = ST_IDLE;
          out_valid_d     = 1'b0;
          flush_pending_d = 1'b0;
          // A flush (pending, or arriving now) beats the Cr wrap and its mcu_done.
          if (flush || flush_pending_q) begin
            seq_pos_d = '0;
          end else if (seq_pos_q == CR_POS) begin
            seq_pos_d  = '0;
            mcu_done_d = 1'b1;
          end else begin
            seq_pos_d = seq_pos_q + 3'd1;
          end
        end else if (flush) begin
          flush_pending_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. An async reset discards any block in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      seq_pos_q       <= '0;
      lat_cnt_q       <= '0;
      flush_pending_q <= 1'b0;
      y_ack_q         <= 1'b0;
      cb_ack_q        <= 1'b0;
      cr_ack_q        <= 1'b0;
      src_sel_q       <= COMP_Y;
      dct_enable_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      out_comp_q      <= COMP_Y;
      out_idx_q       <= '0;
      mcu_done_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop
      // samples its pre-edge value, whatever order the statements are written in.
      state_q         <= state_d;
      seq_pos_q       <= seq_pos_d;
      lat_cnt_q       <= lat_cnt_d;
      flush_pending_q <= flush_pending_d;
      y_ack_q         <= y_ack_d;
      cb_ack_q        <= cb_ack_d;
      cr_ack_q        <= cr_ack_d;
      src_sel_q       <= src_sel_d;
      dct_enable_q    <= dct_enable_d;
      out_valid_q     <= out_valid_d;
      out_comp_q      <= out_comp_d;
      out_idx_q       <= out_idx_d;
      mcu_done_q      <= mcu_done_d;
    end
  end

  assign y_ack      = y_ack_q;
  assign cb_ack     = cb_ack_q;
  assign cr_ack     = cr_ack_q;
  assign src_sel    = src_sel_q;
  assign dct_enable = dct_enable_q;
  assign out_valid  = out_valid_q;
  assign out_comp   = out_comp_q;
  assign out_idx    = out_idx_q;
  assign mcu_done   = mcu_done_q;

`ifdef DCT_SCHED_STATS_EN
  logic [CNT_W-1:0] stat_blocks_q, stat_blocks_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // Saturating counters for accepted blocks and backpressure cycles. Flush clears them.
  always_comb begin
    stat_blocks_d = stat_blocks_q;
    stat_stall_d  = stat_stall_q;
    if (flush) begin
      stat_blocks_d = '0;
      stat_stall_d  = '0;
    end else begin
      if (out_valid_q && out_ready && (stat_blocks_q != '1))
        stat_blocks_d = stat_blocks_q + 1'b1;
      if (out_valid_q && !out_ready && (stat_stall_q != '1))
        stat_stall_d = stat_stall_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_blocks_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_blocks_q <= stat_blocks_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_blocks = stat_blocks_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_blocks = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_dct_mcu_sched.sv
// tb_dct_mcu_sched: directed testbench for dct_mcu_sched with its default parameters
// (Y_BLOCKS=4, DCT_LATENCY=24, CNT_W=16). The expected statistics values depend on
// DCT_SCHED_STATS_EN.
module tb_dct_mcu_sched;

  localparam int CNT_W = 16;
  localparam int OUTW  = 13 + 2 * CNT_W;
`ifdef DCT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             y_req = 1'b0, cb_req = 1'b0, cr_req = 1'b0;
  logic             flush = 1'b0, out_ready = 1'b0;
  logic             y_ack, cb_ack, cr_ack, dct_enable, out_valid, mcu_done;
  logic [1:0]       src_sel, out_comp;
  logic [2:0]       out_idx;
  logic [CNT_W-1:0] stat_blocks, stat_stall;

  int errors = 0;
  int checks = 0;
  int mcu_cnt = 0;

  wire [OUTW-1:0] all_outs = {y_ack, cb_ack, cr_ack, src_sel, dct_enable, out_valid,
                              out_comp, out_idx, mcu_done, stat_blocks, stat_stall};

  dct_mcu_sched #(.Y_BLOCKS(4), .DCT_LATENCY(24), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .y_req(y_req), .cb_req(cb_req), .cr_req(cr_req),
    .y_ack(y_ack), .cb_ack(cb_ack), .cr_ack(cr_ack),
    .src_sel(src_sel), .dct_enable(dct_enable), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_comp(out_comp), .out_idx(out_idx), .mcu_done(mcu_done),
    .stat_blocks(stat_blocks), .stat_stall(stat_stall)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mcu_done === 1'b1) mcu_cnt <= mcu_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    {y_req, cb_req, cr_req, flush, out_ready} = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (y_ack || cb_ack || cr_ack) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack_idx(input int budget, input logic [2:0] idx, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((y_ack || cb_ack || cr_ack) && out_idx == idx) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {y_req, cb_req, cr_req, out_ready} = 4'b1111;
    #2;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_async: outs=%h expected 0", all_outs); end
    tick();
    tick();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_held: outs=%h expected 0", all_outs); end
    {y_req, cb_req, cr_req, out_ready} = '0;
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_idle: outs=%h expected 0", all_outs); end
  endtask

  // All requests held high with out_ready=1: two full MCUs in 4:2:0 order.
  task automatic test_order();
    int n_ack = 0, n_done = 0;
    bit prev_en = 0, prev_done = 0;
    logic [1:0] exp_c, last_c = 2'd0;
    logic [2:0] exp_i;
    apply_reset();
    {y_req, cb_req, cr_req, out_ready} = 4'b1111;
    for (int cyc = 0; cyc < 400 && n_done < 2; cyc++) begin
      tick();
      if (prev_en) begin
        checks++;
        if (dct_enable !== 1'b0) begin errors++; $display("FAIL order_en_width: dct_enable=%b expected 0", dct_enable); end
      end
      if (prev_done) begin
        checks++;
        if (mcu_done !== 1'b0) begin errors++; $display("FAIL order_done_width: mcu_done=%b expected 0", mcu_done); end
      end
      if (y_ack || cb_ack || cr_ack || dct_enable) begin
        exp_i = 3'(n_ack % 6);
        exp_c = (exp_i < 3'd4) ? 2'd0 : (exp_i == 3'd4) ? 2'd1 : 2'd2;
        checks++;
        if ({y_ack, cb_ack, cr_ack, dct_enable, src_sel, out_comp, out_idx} !==
            {exp_c == 2'd0, exp_c == 2'd1, exp_c == 2'd2, 1'b1, exp_c, exp_c, exp_i}) begin
          errors++;
          $display("FAIL order_blk%0d: ack=%b%b%b en=%b sel=%0d comp=%0d idx=%0d expected comp %0d idx %0d",
                   n_ack, y_ack, cb_ack, cr_ack, dct_enable, src_sel, out_comp, out_idx, exp_c, exp_i);
        end
        last_c = out_comp;
        n_ack++;
      end
      if (mcu_done) begin
        checks++;
        if ({last_c, 3'(n_ack % 6)} !== {2'd2, 3'd0}) begin
          errors++;
          $display("FAIL order_mcu_done: last comp=%0d acks=%0d expected Cr after a multiple of 6", last_c, n_ack);
        end
        n_done++;
      end
      prev_en = dct_enable;
      prev_done = mcu_done;
    end
    checks++;
    if (n_ack !== 12 || n_done !== 2) begin
      errors++;
      $display("FAIL order_totals: acks=%0d mcu_done=%0d expected 12 and 2", n_ack, n_done);
    end
    {y_req, cb_req, cr_req, out_ready} = '0;
  endtask

  // A single y_req pulse gives the ack/start one cycle later and out_valid DCT_LATENCY
  // cycles after that. A 7-cycle stall must then hold the output stable.
  task automatic test_latency_stall();
    bit early = 0;
    apply_reset();
    repeat (8) tick();
    y_req = 1'b1;
    tick();
    checks++;
    if ({y_ack, cb_ack, cr_ack, dct_enable, src_sel, out_comp, out_idx, out_valid} !== {4'b1001, 2'd0, 2'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL lat_start: ack=%b%b%b en=%b sel=%0d comp=%0d idx=%0d valid=%b expected Y start idx 0",
               y_ack, cb_ack, cr_ack, dct_enable, src_sel, out_comp, out_idx, out_valid);
    end
    y_req = 1'b0;
    tick();
    checks++;
    if ({y_ack, dct_enable} !== 2'b00) begin errors++; $display("FAIL lat_pulse: y_ack=%b en=%b expected 0 0", y_ack, dct_enable); end
    for (int k = 2; k <= 23; k++) begin
      tick();
      early |= out_valid;
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid seen before latency expired"); end
    tick();
    checks++;
    if ({out_valid, out_comp, out_idx, src_sel} !== {1'b1, 2'd0, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL lat_valid: valid=%b comp=%0d idx=%0d sel=%0d expected 1 0 0 0", out_valid, out_comp, out_idx, src_sel);
    end
    {y_req, cb_req, cr_req} = 3'b111;
    for (int s = 0; s < 7; s++) begin
      tick();
      checks++;
      if ({out_valid, out_comp, out_idx, src_sel, dct_enable, y_ack, cb_ack, cr_ack} !== {1'b1, 2'd0, 3'd0, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b comp=%0d idx=%0d sel=%0d en=%b acks=%b%b%b", s,
                 out_valid, out_comp, out_idx, src_sel, dct_enable, y_ack, cb_ack, cr_ack);
      end
    end
    checks++;
    if (stat_stall !== (STATS ? 16'd7 : 16'd0) || stat_blocks !== 16'd0) begin
      errors++;
      $display("FAIL stall_count: stall=%0d blocks=%0d expected %0d 0", stat_stall, stat_blocks, STATS ? 7 : 0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, mcu_done} !== 2'b00 || stat_blocks !== (STATS ? 16'd1 : 16'd0) || stat_stall !== (STATS ? 16'd7 : 16'd0)) begin
      errors++;
      $display("FAIL stall_accept: valid=%b done=%b blocks=%0d stall=%0d", out_valid, mcu_done, stat_blocks, stat_stall);
    end
    tick();
    checks++;
    if ({y_ack, dct_enable, out_idx} !== {2'b11, 3'd1}) begin
      errors++;
      $display("FAIL back_to_back: y_ack=%b en=%b idx=%0d expected 1 1 1", y_ack, dct_enable, out_idx);
    end
    {y_req, cb_req, cr_req, out_ready} = '0;
  endtask

  // Cb is expected but only Cr (and Y, once exhausted) request: nothing may be served.
  task automatic test_strict_order();
    int ny = 0, ncb = 0, ncr = 0;
    apply_reset();
    {y_req, cb_req, cr_req, out_ready} = 4'b1011;
    for (int c = 0; c < 220; c++) begin
      tick();
      if (y_ack) ny++;
      if (cb_ack) ncb++;
      if (cr_ack) ncr++;
    end
    checks++;
    if (ny !== 4 || ncb !== 0 || ncr !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL strict_skip: y=%0d cb=%0d cr=%0d valid=%b expected 4 0 0 0", ny, ncb, ncr, out_valid);
    end
    y_req = 1'b0;
    cb_req = 1'b1;
    tick();
    checks++;
    if ({cb_ack, cr_ack, dct_enable, out_comp, out_idx, src_sel} !== {3'b101, 2'd1, 3'd4, 2'd1}) begin
      errors++;
      $display("FAIL strict_cb: cb_ack=%b cr_ack=%b en=%b comp=%0d idx=%0d sel=%0d expected Cb idx 4",
               cb_ack, cr_ack, dct_enable, out_comp, out_idx, src_sel);
    end
    {y_req, cb_req, cr_req, out_ready} = '0;
  endtask

  // A flush during Y2's WAIT keeps the Y2 tag, then restarts at Y0 without mcu_done.
  task automatic test_flush_wait();
    bit found;
    int m0;
    apply_reset();
    {y_req, out_ready} = 2'b11;
    m0 = mcu_cnt;
    wait_ack_idx(100, 3'd2, found);
    checks++;
    if (!found) begin errors++; $display("FAIL flush_wait_y2: Y2 ack not seen within budget"); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid(40, found);
    checks++;
    if (!found || out_idx !== 3'd2 || out_comp !== 2'd0) begin
      errors++;
      $display("FAIL flush_wait_tag: found=%b idx=%0d comp=%0d expected idx 2 comp 0", found, out_idx, out_comp);
    end
    wait_ack(10, found);
    checks++;
    if (!found || {y_ack, out_idx, out_comp} !== {1'b1, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL flush_wait_restart: found=%b y_ack=%b idx=%0d comp=%0d expected Y idx 0", found, y_ack, out_idx, out_comp);
    end
    checks++;
    if (stat_blocks !== (STATS ? 16'd1 : 16'd0) || mcu_cnt - m0 !== 0) begin
      errors++;
      $display("FAIL flush_wait_stats: blocks=%0d mcu_done pulses=%0d expected %0d and 0", stat_blocks, mcu_cnt - m0, STATS ? 1 : 0);
    end
    {y_req, out_ready} = '0;
  endtask

  // Flush arriving on the same edge as the Cr acceptance suppresses mcu_done.
  task automatic test_flush_cr();
    bit found;
    int m0;
    apply_reset();
    {y_req, cb_req, cr_req, out_ready} = 4'b1111;
    wait_ack_idx(200, 3'd5, found);
    checks++;
    if (!found || out_comp !== 2'd2) begin errors++; $display("FAIL flush_cr_start: found=%b comp=%0d expected Cr", found, out_comp); end
    out_ready = 1'b0;
    wait_valid(40, found);
    checks++;
    if (!found) begin errors++; $display("FAIL flush_cr_valid: Cr output not seen within budget"); end
    tick();
    m0 = mcu_cnt;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, mcu_done} !== 2'b00 || stat_blocks !== 16'd0 || stat_stall !== 16'd0) begin
      errors++;
      $display("FAIL flush_cr_accept: valid=%b done=%b blocks=%0d stall=%0d expected all 0", out_valid, mcu_done, stat_blocks, stat_stall);
    end
    tick();
    checks++;
    if ({y_ack, dct_enable, out_idx} !== {2'b11, 3'd0} || mcu_cnt - m0 !== 0) begin
      errors++;
      $display("FAIL flush_cr_next: y_ack=%b en=%b idx=%0d mcu_done pulses=%0d expected Y0 and 0", y_ack, dct_enable, out_idx, mcu_cnt - m0);
    end
    {y_req, cb_req, cr_req} = '0;
  endtask

  // A flush sampled in IDLE starts nothing in that cycle and resets the position to Y0.
  task automatic test_flush_idle();
    bit found;
    apply_reset();
    {y_req, out_ready} = 2'b11;
    wait_ack(5, found);
    y_req = 1'b0;
    wait_valid(40, found);
    tick();
    tick();
    flush = 1'b1;
    y_req = 1'b1;
    tick();
    checks++;
    if ({y_ack, dct_enable} !== 2'b00) begin errors++; $display("FAIL flush_idle_nostart: y_ack=%b en=%b expected 0 0", y_ack, dct_enable); end
    flush = 1'b0;
    tick();
    checks++;
    if ({y_ack, out_idx} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL flush_idle_idx: y_ack=%b idx=%0d expected 1 0", y_ack, out_idx);
    end
    {y_req, out_ready} = '0;
  endtask

  // Reset during OUT of Y1 clears everything. After release, Y0 is served first.
  task automatic test_reset_mid();
    bit found;
    apply_reset();
    {y_req, cb_req, cr_req, out_ready} = 4'b1111;
    wait_ack_idx(100, 3'd1, found);
    out_ready = 1'b0;
    wait_valid(40, found);
    checks++;
    if (!found || out_idx !== 3'd1) begin errors++; $display("FAIL rstmid_out: found=%b idx=%0d expected Y1 output", found, out_idx); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL rstmid_async: outs=%h expected 0", all_outs); end
    tick();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL rstmid_held: outs=%h expected 0", all_outs); end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({y_ack, cb_ack, cr_ack, dct_enable, out_idx, out_comp, out_valid} !== {4'b1001, 3'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_first: ack=%b%b%b en=%b idx=%0d comp=%0d valid=%b expected Y0 start",
               y_ack, cb_ack, cr_ack, dct_enable, out_idx, out_comp, out_valid);
    end
    {y_req, cb_req, cr_req} = '0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_latency_stall();
    test_strict_order();
    test_flush_wait();
    test_flush_cr();
    test_flush_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dct_mcu_sched.md
Name: dct_mcu_sched

Overview:
Sequences 8x8 blocks from the Y, Cb and Cr block buffers into the single shared DCT_2D engine in JPEG MCU order. With the default Y_BLOCKS = 4 this is 4:2:0 order: Y0 Y1 Y2 Y3 Cb Cr.
- Drives the engine's start pulse and pixel-source mux select.
- Times the engine's fixed latency.
- Presents a tagged valid/ready result toward the quantizer stage.
- Exactly one block is in flight at a time.

Parameters:
Y_BLOCKS, 4, Y blocks per MCU (1, 2 or 4); Cb then Cr follow.
DCT_LATENCY, 24, clocks from dct_enable high to engine `out` valid (must be >= 2).
CNT_W, 16, width of statistics counters.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
y_req  in  1  Y buffer holds a complete block
cb_req  in  1  Cb buffer holds a complete block
cr_req  in  1  Cr buffer holds a complete block
y_ack  out  1  one-cycle pulse: Y block consumed
cb_ack  out  1  one-cycle pulse: Cb block consumed
cr_ack  out  1  one-cycle pulse: Cr block consumed
src_sel  out  2  engine pix_data mux: 0=Y, 1=Cb, 2=Cr (held stable until the block is accepted)
dct_enable  out  1  one-cycle start pulse to DCT_2D
flush  in  1  synchronous: restart MCU sequence at Y0
out_valid  out  1  engine output holds a finished block
out_ready  in  1  downstream accepts the block
out_comp  out  2  component tag of the current block (same encoding as src_sel)
out_idx  out  3  position of the block within the MCU (0..Y_BLOCKS+1)
mcu_done  out  1  one-cycle pulse when the Cr block is accepted
stat_blocks  out  CNT_W  blocks accepted (macro-dependent)
stat_stall  out  CNT_W  cycles with out_valid=1 and out_ready=0 (macro-dependent)

Behaviour:
- Clock and reset: single clock `clock`; `reset_n` is asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; seq_pos = 0; latency counter 0; flush_pending 0.
- Registered outputs: all outputs are registered; no combinational path from input to output.
- Sequence position: seq_pos runs 0..Y_BLOCKS+1.
  - Expected component: Y while seq_pos < Y_BLOCKS, Cb at Y_BLOCKS, Cr at Y_BLOCKS+1.
  - Strict order: a req for a non-expected component is ignored and never skipped ahead to.
- State machine:
  - IDLE: if the expected component's req=1 in cycle n, then in cycle n+1:
    - matching ack=1 and dct_enable=1;
    - src_sel = expected component; out_comp/out_idx = component/seq_pos;
    - state goes to WAIT.
  - WAIT: counter times DCT_LATENCY; out_valid rises in cycle n+1+DCT_LATENCY; state goes to OUT.
  - OUT: out_valid, out_comp, out_idx and src_sel are held stable until out_ready=1 is sampled. On that edge:
    - out_valid goes to 0;
    - stat_blocks increments;
    - seq_pos increments, wrapping Y_BLOCKS+1 -> 0 with mcu_done=1 for one cycle;
    - state goes to IDLE.
- No new block is started before the current one is accepted, because the engine output register would be overwritten.
- Back-to-back throughput: if the next req is already high, acceptance in cycle m gives the next ack/dct_enable in cycle m+2.
- Wrap-around: after a Cr acceptance, the next block expected is Y0.
- flush:
  - Sampled in IDLE: seq_pos <= 0 at that edge, and no block is started in that cycle.
  - Sampled in WAIT or OUT: sets flush_pending; the in-flight block completes normally with its original tag.
  - On return to IDLE: seq_pos <= 0 instead of incrementing, and mcu_done is not pulsed.
  - flush and a Cr acceptance in the same cycle: the flush wins, so seq_pos <= 0 and no mcu_done.
- Reset mid-operation: everything returns to reset values immediately. A block already acked is discarded, and nothing is re-acked after reset.
- Simultaneous reqs: only the expected component is served; the others wait.
- out_ready high while out_valid=0: ignored.
- Counters: saturate at 2^CNT_W-1 (no wrap).

Optional Feature:
DCT_SCHED_STATS_EN
- Defined: stat_blocks and stat_stall are live, saturating counters. Both clear on reset and on flush.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
1. Y_BLOCKS=4, all reqs held high, out_ready=1 -> acks appear in order Y,Y,Y,Y,Cb,Cr; out_idx 0..5; mcu_done is pulsed once per 6 blocks; each dct_enable is exactly 1 cycle wide.
2. y_req pulsed at cycle 10, DCT_LATENCY=24 -> y_ack and dct_enable at cycle 11, out_valid first at cycle 35.
3. out_ready held low for 7 cycles after out_valid -> out_valid/out_comp/src_sel stay stable, no new dct_enable, stat_stall=7 (macro on) or 0 (macro off).
4. seq_pos=4 (Cb expected), only cr_req=1 -> no ack for 50 cycles; then raise cb_req -> cb_ack next cycle, tag 1/4.
5. flush during WAIT of Y2 -> Y2 output still tagged idx 2; next block served is Y0 (idx 0); no mcu_done.
6. reset_n low during OUT, released, all reqs high -> all outputs 0 during reset; first block after release is Y0 with ack 1 cycle after the first IDLE sample.
